// File: rtl/host_wire_bank.sv
// Host wire bank: two-stage wire-in synchroniser with change pulses, plus a coherent wire-out bank.
// Define HOST_WIRE_BANK_SNAPSHOT_EN for request-driven snapshots; otherwise wire_out tracks src_data.
module host_wire_bank #(
    parameter int NUM_IN        = 2,
    parameter int NUM_OUT       = 11,
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_IN*WIDTH-1:0]  host_wire_in,
    output logic [NUM_IN*WIDTH-1:0]  wire_in_q,
    output logic [NUM_IN-1:0]        wire_in_changed,
    input  logic [NUM_OUT*WIDTH-1:0] src_data,
    output logic [NUM_OUT*WIDTH-1:0] wire_out,
    output logic [7:0]               snap_seq,
    output logic                     busy,
    output logic [7:0]               lights
);

    if (NUM_IN < 1 || NUM_IN > 16 || NUM_OUT < 1 || NUM_OUT > 16 ||
        WIDTH < 8 || WIDTH > 32 || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_param_check
        $error("host_wire_bank: parameter out of range");
    end

    logic [NUM_IN*WIDTH-1:0]  sync1_q;
    logic [NUM_IN*WIDTH-1:0]  sync2_q;
    logic [NUM_IN*WIDTH-1:0]  prev_q;
    logic [NUM_IN-1:0]        changed_q;
    logic [NUM_IN-1:0]        changed_d;
    logic [1:0]               warm_q;
    logic                     warm_done;
    logic [NUM_OUT*WIDTH-1:0] wire_out_q;
    logic [3:0]               sel;

    // Change detection stays blanked until the synchronisers have flushed their reset zeros.
    assign warm_done = (warm_q == 2'd3);

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    always_comb begin
        changed_d = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            changed_d[i] = warm_done && (sync2_q[i*WIDTH +: WIDTH] != prev_q[i*WIDTH +: WIDTH]);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            changed_q <= '0;
            warm_q    <= '0;
        end else begin
            sync1_q   <= host_wire_in;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            changed_q <= changed_d;
            if (!warm_done) warm_q <= warm_q + 2'd1;
        end
    end

`ifdef HOST_WIRE_BANK_SNAPSHOT_EN
    typedef enum logic [1:0] {IDLE, CAPTURE, SETTLE} state_t;

    state_t     state_q;
    logic [7:0] settle_cnt_q;
    logic [7:0] seq_q;
    logic       pending_q;
    logic       busy_q;
    logic       req;

    // A snapshot request is an edge of either polarity on channel 0's top bit.
    assign req = changed_d[0] && (sync2_q[WIDTH-1] != prev_q[WIDTH-1]);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            seq_q        <= '0;
            pending_q    <= 1'b0;
            busy_q       <= 1'b0;
            wire_out_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req || pending_q) begin
                        state_q   <= CAPTURE;
                        busy_q    <= 1'b1;
                        pending_q <= 1'b0;
                    end
                end
                CAPTURE: begin
                    wire_out_q   <= src_data;
                    seq_q        <= seq_q + 8'd1;
                    settle_cnt_q <= '0;
                    state_q      <= SETTLE;
                    pending_q    <= pending_q | req;
                end
                SETTLE: begin
                    pending_q <= pending_q | req;
                    if (settle_cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign snap_seq = seq_q;
    assign busy     = busy_q;
`else
    always_ff @(posedge clock) begin
        if (reset) wire_out_q <= '0;
        else       wire_out_q <= src_data;
    end

    assign snap_seq = '0;
    assign busy     = 1'b0;
`endif

    // Selects at or beyond NUM_OUT match no channel and leave the LEDs dark.
    assign sel = sync2_q[3:0];

    always_comb begin
        lights = 8'hFF;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (sel == i[3:0]) lights = ~wire_out_q[i*WIDTH +: 8];
        end
    end

    assign wire_in_q       = sync2_q;
    assign wire_in_changed = changed_q;
    assign wire_out        = wire_out_q;

endmodule

// File: tb/tb_host_wire_bank.sv
// Self-checking bench for host_wire_bank; covers both the snapshot and pass-through builds.
module tb_host_wire_bank;

    localparam int NUM_IN  = 2;
    localparam int NUM_OUT = 11;
    localparam int WIDTH   = 16;
    localparam int SETTLE  = 4;
    localparam int IW      = NUM_IN * WIDTH;
    localparam int OW      = NUM_OUT * WIDTH;
`ifdef HOST_WIRE_BANK_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [IW-1:0] host_wire_in = '0;
    logic [IW-1:0] wire_in_q;
    logic [NUM_IN-1:0] wire_in_changed;
    logic [OW-1:0] src_data = '0;
    logic [OW-1:0] wire_out;
    logic [7:0]    snap_seq;
    logic          busy;
    logic [7:0]    lights;

    host_wire_bank #(
        .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clock(clock), .reset(reset), .host_wire_in(host_wire_in), .wire_in_q(wire_in_q),
        .wire_in_changed(wire_in_changed), .src_data(src_data), .wire_out(wire_out),
        .snap_seq(snap_seq), .busy(busy), .lights(lights)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;
    int busy_cnt = 0;
    int chg_cnt = 0;

    // Reference model: edge-indexed timeline of the expected outputs.
    logic [IW-1:0]     m_wq = '0, m_wq_old = '0, m_host_prev = '0;
    logic              m_rst_prev = 1'b1;
    int                m_since_rst = 0;
    logic [NUM_IN-1:0] m_chg = '0;
    logic [OW-1:0]     m_wout = '0;
    logic [7:0]        m_seq = '0;
    logic              m_busy = 1'b0;
    logic [7:0]        m_lights = 8'hFF;
    int                m_edge = 0, m_start = 0;
    bit                m_have = 1'b0, m_pend = 1'b0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit req, busy_before;
        int sel;
        m_edge++;
        busy_before = m_busy;
        req = 1'b0;
        if (reset) begin
            m_chg = '0; m_wq = '0; m_wq_old = '0; m_since_rst = 0;
            m_wout = '0; m_seq = '0; m_busy = 1'b0; m_pend = 1'b0; m_have = 1'b0;
        end else begin
            for (int i = 0; i < NUM_IN; i++)
                m_chg[i] = (m_since_rst >= 3) && (m_wq[i*WIDTH +: WIDTH] != m_wq_old[i*WIDTH +: WIDTH]);
            req = (m_since_rst >= 3) && (m_wq[WIDTH-1] != m_wq_old[WIDTH-1]);
            if (m_since_rst < 3) m_since_rst++;
            m_wq_old = m_wq;
            m_wq = m_rst_prev ? '0 : m_host_prev;
            if (SNAP) begin
                // A snapshot window spans edges start..start+SETTLE; data loads one edge after start.
                if (!busy_before && (req || m_pend)) begin
                    m_start = m_edge; m_have = 1'b1; m_pend = 1'b0;
                end else if (busy_before && req) begin
                    m_pend = 1'b1;
                end
                if (m_have && m_edge == m_start + 1) begin
                    m_wout = src_data;
                    m_seq = m_seq + 8'd1;
                end
                m_busy = m_have && (m_edge >= m_start) && (m_edge <= m_start + SETTLE);
            end else begin
                m_wout = src_data;
            end
        end
        m_host_prev = host_wire_in;
        m_rst_prev = reset;
        sel = int'(m_wq[3:0]);
        m_lights = (sel < NUM_OUT) ? ~m_wout[sel*WIDTH +: 8] : 8'hFF;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        busy_cnt += int'(busy);
        if (|wire_in_changed) chg_cnt++;
        check("wire_in_q", 256'(wire_in_q), 256'(m_wq));
        check("wire_in_changed", 256'(wire_in_changed), 256'(m_chg));
        check("wire_out", 256'(wire_out), 256'(m_wout));
        check("snap_seq", 256'(snap_seq), 256'(m_seq));
        check("busy", 256'(busy), 256'(m_busy));
        check("lights", 256'(lights), 256'(m_lights));
    endtask

    task automatic toggle_req();
        host_wire_in[WIDTH-1] = ~host_wire_in[WIDTH-1];
    endtask

    task automatic randomize_src();
        for (int i = 0; i < NUM_OUT; i++) src_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    endtask

    initial begin
        int seq0;

        // Reset with ch0 = 8000 held through release: no pulses, no snapshot, dark LEDs.
        host_wire_in[15:0] = 16'h8000;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (8) tick();
        check("rel_no_changed", 256'(chg_cnt), 256'(0));
        check("rel_snap_seq", 256'(snap_seq), 256'(0));
        check("rel_lights", 256'(lights), 256'(8'hFF));

        // One snapshot of ch2 = 00A5, select = 2.
        randomize_src();
        src_data[2*WIDTH +: WIDTH] = 16'h00A5;
        tick();
        busy_cnt = 0;
        host_wire_in[15:0] = 16'h0002;
        tick(); tick(); tick();
        check("lat_before_k3", 256'(wire_out[2*WIDTH +: WIDTH]), 256'(SNAP ? 16'h0000 : 16'h00A5));
        tick();
        check("lat_at_k3", 256'(wire_out[2*WIDTH +: WIDTH]), 256'(16'h00A5));
        // Live data moves while settling; the snapshot must hold.
        randomize_src();
        repeat (10) tick();
        check("busy_len", 256'(busy_cnt), 256'(SNAP ? 1 + SETTLE : 0));
        check("seq_one", 256'(snap_seq), 256'(SNAP ? 1 : 0));
        src_data[2*WIDTH +: WIDTH] = 16'h00A5;
        repeat (2) tick();
        check("lights_sel2", 256'(lights), 256'(8'h5A));

        host_wire_in[3:0] = 4'hF;
        repeat (4) tick();
        check("lights_sel15", 256'(lights), 256'(8'hFF));
        host_wire_in[3:0] = 4'h2;
        repeat (4) tick();

        // Two requests while settling collapse into one extra capture.
        seq0 = int'(snap_seq);
        busy_cnt = 0;
        toggle_req();
        repeat (4) tick();
        toggle_req(); tick();
        toggle_req(); tick();
        repeat (20) tick();
        check("collapse_seq", 256'(snap_seq), 256'(SNAP ? 8'(seq0 + 2) : 8'd0));
        check("collapse_busy", 256'(busy_cnt), 256'(SNAP ? 2 * (1 + SETTLE) : 0));

        // Randomised traffic.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(3) == 0) host_wire_in[IW-1:WIDTH] = (IW - WIDTH)'($urandom);
            if ($urandom_range(3) == 0) host_wire_in[3:0] = 4'($urandom);
            if ($urandom_range(7) == 0) toggle_req();
            if ($urandom_range(1) == 0) randomize_src();
            tick();
        end

        // 257 snapshots from reset wrap the sequence counter to 1.
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();
        for (int n = 0; n < 257; n++) begin
            toggle_req();
            randomize_src();
            repeat (SETTLE + 3) tick();
        end
        repeat (6) tick();
        check("seq_wrap", 256'(snap_seq), 256'(SNAP ? 1 : 0));

        // Reset mid-SETTLE aborts the snapshot.
        toggle_req();
        randomize_src();
        repeat (5) tick();
        check("mid_settle_busy", 256'(busy), 256'(SNAP));
        reset = 1'b1;
        tick();
        check("abort_busy", 256'(busy), 256'(0));
        check("abort_wire_out", 256'(wire_out), 256'(0));
        reset = 1'b0;
        repeat (12) tick();
        check("abort_seq", 256'(snap_seq), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/host_wire_bank.md
HOST_WIRE_BANK -- requirements
Module: host_wire_bank

Interface
REQ-001 Parameter NUM_IN, default 2, number of host wire-in channels (1..16).
REQ-002 Parameter NUM_OUT, default 11, number of host wire-out channels (1..16).
REQ-003 Parameter WIDTH, default 16, bits per channel (8..32).
REQ-004 Parameter SETTLE_CYCLES, default 4, post-capture hold cycles (1..255).
REQ-005 clock  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 host_wire_in  in  NUM_IN*WIDTH  raw host wire-in values; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 wire_in_q  out  NUM_IN*WIDTH  synchronised wire-in values.
REQ-009 wire_in_changed  out  NUM_IN  per-channel one-cycle change pulse.
REQ-010 src_data  in  NUM_OUT*WIDTH  live fabric values for the wire-outs.
REQ-011 wire_out  out  NUM_OUT*WIDTH  coherent wire-out values presented to the host.
REQ-012 snap_seq  out  8  snapshot sequence counter.
REQ-013 busy  out  1  high while capturing or settling.
REQ-014 lights  out  8  active-low LED drive.

Function
REQ-015 host_wire_in shall pass through two register stages; wire_in_q shall reflect a value sampled at edge k after edge k+1.
REQ-016 wire_in_changed[i] shall pulse high for exactly one cycle, after edge k+2, when channel i of wire_in_q differs from its previous-cycle value.
REQ-017 Snapshot request: a transition of either polarity on wire_in_q channel 0 bit WIDTH-1, detected alongside wire_in_changed[0].
REQ-018 FSM states: IDLE, CAPTURE, SETTLE.
REQ-019 IDLE -> CAPTURE on a request or a set pending flag; CAPTURE lasts one cycle, loads every wire_out channel from src_data, and increments snap_seq modulo 256 (255 -> 0); CAPTURE -> SETTLE.
REQ-020 SETTLE shall last exactly SETTLE_CYCLES cycles, then return to IDLE; wire_out shall be stable from CAPTURE until the next CAPTURE.
REQ-021 A request arriving in CAPTURE or SETTLE shall set pending; multiple requests shall collapse to one; pending shall clear on entry to CAPTURE.
REQ-022 Request latency: host toggle sampled at edge k results in wire_out being updated after edge k+3 from IDLE.
REQ-023 busy shall be high in CAPTURE and SETTLE, low in IDLE.
REQ-024 wire_in_q channel 0 bits [3:0] shall select the wire_out channel for lights; lights shall equal the bitwise inverse of the low 8 bits of that channel.
REQ-025 A select value >= NUM_OUT shall force lights to 8'hFF.
REQ-026 Request detection and wire_in_changed shall be suppressed for the first 3 cycles after reset deasserts, to avoid spurious pulses while the synchronisers fill.

Reset
REQ-027 reset shall clear to 0: synchronisers, wire_in_q, wire_in_changed, wire_out, snap_seq, busy and pending; the FSM shall enter IDLE; lights shall read 8'hFF.
REQ-028 reset asserted during CAPTURE or SETTLE shall abort the snapshot and discard pending.

Configuration
REQ-029 Macro HOST_WIRE_BANK_SNAPSHOT_EN defined: snapshot FSM as in REQ-017..REQ-023.
REQ-030 Macro undefined: no FSM; wire_out shall register src_data every cycle (1-cycle latency); snap_seq and busy shall be tied to 0; REQ-015/016/024..026 shall be unchanged.

Verification
REQ-031 Reset, then hold host_wire_in ch0 = 16'h8000 through release -> no wire_in_changed, no snapshot, snap_seq = 0, lights = 8'hFF.
REQ-032 src_data ch2 = 16'h00A5; toggle ch0 bit15 at edge k -> wire_out ch2 = 16'h00A5 after edge k+3, busy high 1+SETTLE_CYCLES cycles, snap_seq = 1.
REQ-033 Change src_data during SETTLE -> wire_out stays unchanged until the next request.
REQ-034 Two toggles during SETTLE -> exactly one extra CAPTURE immediately after SETTLE; snap_seq +2 total.
REQ-035 Select = 2 with wire_out ch2 = 16'h00A5 -> lights = 8'h5A; select = 15 with NUM_OUT = 11 -> lights = 8'hFF.
REQ-036 257 snapshots -> snap_seq = 1 (wrap); reset asserted mid-SETTLE -> IDLE, busy = 0, wire_out = 0 on the next cycle.
